// File: rtl/md_scheduler.sv
// HI/LO multiply/divide sequencer: accepts an md op, holds the result in a
// shadow pair for a fixed latency, then commits it. Define MD_MADD_EN to enable MADD/MADDU.
module md_scheduler #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [31:0] hi_n_q, hi_n_d, lo_n_q, lo_n_d;
    logic        done_q, done_d;

    logic [63:0] prod_s, prod_u;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, b_mag_safe, b_u_safe;
    logic [31:0] quo_mag, rem_mag, quo_s, rem_s, quo_u, rem_u;

    always_comb begin
        prod_s = $signed({{32{src_a[31]}}, src_a}) * $signed({{32{src_b[31]}}, src_b});
        prod_u = {32'd0, src_a} * {32'd0, src_b};

        // Signed divide via magnitudes so that 0x80000000 / -1 wraps cleanly.
        a_neg      = src_a[31];
        b_neg      = src_b[31];
        a_mag      = a_neg ? (32'd0 - src_a) : src_a;
        b_mag      = b_neg ? (32'd0 - src_b) : src_b;
        b_mag_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
        b_u_safe   = (src_b == 32'd0) ? 32'd1 : src_b;
        quo_mag    = a_mag / b_mag_safe;
        rem_mag    = a_mag % b_mag_safe;
        quo_s      = (a_neg ^ b_neg) ? (32'd0 - quo_mag) : quo_mag;
        rem_s      = a_neg ? (32'd0 - rem_mag) : rem_mag;
        quo_u      = src_a / b_u_safe;
        rem_u      = src_a % b_u_safe;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        hi_n_d  = hi_n_q;
        lo_n_d  = lo_n_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    case (op)
                        3'd0: begin
                            {hi_n_d, lo_n_d} = prod_s;
                            cnt_d   = 4'(MULT_LAT);
                            state_d = RUN;
                        end
                        3'd1: begin
                            {hi_n_d, lo_n_d} = prod_u;
                            cnt_d   = 4'(MULT_LAT);
                            state_d = RUN;
                        end
                        3'd2: begin
                            // A zero divisor still runs the full latency but commits the old HI/LO.
                            hi_n_d  = (src_b == 32'd0) ? hi_q : rem_s;
                            lo_n_d  = (src_b == 32'd0) ? lo_q : quo_s;
                            cnt_d   = 4'(DIV_LAT);
                            state_d = RUN;
                        end
                        3'd3: begin
                            hi_n_d  = (src_b == 32'd0) ? hi_q : rem_u;
                            lo_n_d  = (src_b == 32'd0) ? lo_q : quo_u;
                            cnt_d   = 4'(DIV_LAT);
                            state_d = RUN;
                        end
                        3'd4: hi_d = src_a;
                        3'd5: lo_d = src_a;
`ifdef MD_MADD_EN
                        3'd6: begin
                            {hi_n_d, lo_n_d} = {hi_q, lo_q} + prod_s;
                            cnt_d   = 4'(MULT_LAT);
                            state_d = RUN;
                        end
                        3'd7: begin
                            {hi_n_d, lo_n_d} = {hi_q, lo_q} + prod_u;
                            cnt_d   = 4'(MULT_LAT);
                            state_d = RUN;
                        end
`endif
                        default: ;
                    endcase
                end
            end
            RUN: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    hi_d    = hi_n_q;
                    lo_d    = lo_n_q;
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            hi_n_q  <= 32'd0;
            lo_n_q  <= 32'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            hi_n_q  <= hi_n_d;
            lo_n_q  <= lo_n_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_md_scheduler.sv
// Scoreboard bench for md_scheduler: timed ops push expected HI/LO and busy
// length; a monitor compares on every done pulse.
module tb_md_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] src_a = 32'd0;
    logic [31:0] src_b = 32'd0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   bcnt = 0;

    md_scheduler #(.MULT_LAT(5), .DIV_LAT(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .src_a(src_a), .src_b(src_b),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] h, input logic [31:0] l, input int lat);
        exp_t e;
        e.hi = h; e.lo = l; e.lat = lat;
        sb.push_back(e);
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1; op = o; src_a = a; src_b = b;
        @(negedge clk);
        start = 1'b0;
        $display("issue op=%0d a=0x%08h b=0x%08h", o, a, b);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && busy; i++) @(negedge clk);
        if (busy) chk("wait_idle_timeout", 32'(busy), 32'd0);
        @(negedge clk);
    endtask

    // Monitor: counts busy cycles and checks each commit against the scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            bcnt = 0;
        end else begin
            if (busy) bcnt++;
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("done_hi", hi, e.hi);
                    chk("done_lo", lo, e.lo);
                    chk("busy_len", 32'(bcnt), 32'(e.lat));
                    $display("done hi=0x%08h lo=0x%08h busy_cycles=%0d", hi, lo, bcnt);
                end
                bcnt = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 reset = 1'b0;
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        @(negedge clk);
        #1 reset = 1'b1;

        push(32'hFFFFFFFF, 32'hFFFFFFFA, 5);
        issue(3'd0, 32'hFFFFFFFE, 32'd3);
        wait_idle();

        push(32'h00000002, 32'hFFFFFFFA, 5);
        issue(3'd1, 32'hFFFFFFFE, 32'd3);
        wait_idle();

        push(32'hFFFFFFFF, 32'hFFFFFFFD, 10);
        issue(3'd2, 32'hFFFFFFF9, 32'd2);
        wait_idle();

        issue(3'd4, 32'h11, 32'd0);
        issue(3'd5, 32'h22, 32'd0);
        chk("mt_busy", 32'(busy), 32'd0);
        push(32'h11, 32'h22, 10);
        issue(3'd3, 32'd7, 32'd0);
        wait_idle();

        // Back-to-back MTHI/MTLO, busy sampled every cycle.
        @(negedge clk);
        start = 1'b1; op = 3'd4; src_a = 32'h1234;
        @(negedge clk);
        chk("mthi_busy", 32'(busy), 32'd0);
        op = 3'd5; src_a = 32'h5678;
        @(negedge clk);
        start = 1'b0;
        chk("mtlo_busy", 32'(busy), 32'd0);
        chk("mt_hi", hi, 32'h1234);
        chk("mt_lo", lo, 32'h5678);
        @(negedge clk);
        chk("mt_busy_after", 32'(busy), 32'd0);
        $display("mthi/mtlo hi=0x%08h lo=0x%08h", hi, lo);

        push(32'h0, 32'h80000000, 10);
        issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
        wait_idle();

        push(32'h2, 32'hE, 10);
        issue(3'd3, 32'd100, 32'd7);
        wait_idle();

        push(32'h40000000, 32'h0, 5);
        issue(3'd0, 32'h80000000, 32'h80000000);
        wait_idle();

        // Starts during RUN must be ignored; original result lands on schedule.
        push(32'h0, 32'h2A, 5);
        issue(3'd0, 32'd7, 32'd6);
        start = 1'b1; op = 3'd0; src_a = 32'hFFFFFFFF; src_b = 32'hFFFFFFFF;
        @(negedge clk);
        op = 3'd4; src_a = 32'hDEAD;
        @(negedge clk);
        start = 1'b0;
        chk("run_ignore_hi", hi, 32'h40000000);
        wait_idle();
        chk("run_ignore_busy", 32'(busy), 32'd0);

        push(32'h1, 32'hFFFFFFFD, 10);
        issue(3'd2, 32'd7, 32'hFFFFFFFE);
        wait_idle();

`ifdef MD_MADD_EN
        push(32'h2, 32'h3, 5);
        issue(3'd6, 32'd2, 32'd3);
        wait_idle();
`else
        issue(3'd6, 32'd2, 32'd3);
        chk("madd_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("madd_hi", hi, 32'h1);
        chk("madd_lo", lo, 32'hFFFFFFFD);
        chk("madd_done", 32'(done), 32'd0);
`endif

        // Reset in the third busy cycle of a DIV.
        issue(3'd3, 32'd100, 32'd7);
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_hi", hi, 32'd0);
        chk("midrst_lo", lo, 32'd0);
        @(negedge clk);
        #1 reset = 1'b1;
        repeat (15) @(negedge clk);
        chk("postrst_busy", 32'(busy), 32'd0);
        chk("postrst_hi", hi, 32'd0);
        $display("reset mid-div hi=0x%08h lo=0x%08h", hi, lo);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
